// File: rtl/sfp_link_pkg.sv
// Shared types and constants for the SFP+ link bring-up controller.
// Optional statistics counters are enabled with the SFP_LINK_STATS_EN macro.
package sfp_link_pkg;

    // Link FSM states; the encodings are visible on the state output.
    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_WAIT_PLL  = 3'd1,
        ST_PHY_RST   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAULT     = 3'd6
    } link_state_e;

    // FAULT LED half-period at 125 MHz, giving a 2 Hz blink.
    localparam int unsigned LED_BLINK_HALF = 31250000;

    // Width of the optional link statistics counters.
    localparam int unsigned STATS_W = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STATS_W-1:0] stats_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/sfp_link_ctrl_if.sv
// Port bundle between one SFP cage / PHY and its link controller.
// Optional statistics signals exist only when SFP_LINK_STATS_EN is defined.
// There is no valid/ready handshake here: every signal is a level, sampled
// by the controller on each clk edge (raw pins are synchronized inside).
interface sfp_link_ctrl_if
    import sfp_link_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 7
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               enable;
    logic               sfp_npres;
    logic               sfp_los;
    logic               qpll_lock;
    logic               rx_block_lock;
    logic               phy_rst;
    logic               sfp_tx_disable;
    logic               sfp_rs;
    logic               link_up;
    logic [1:0]         led;
    logic [2:0]         state;
    logic [RETRY_W-1:0] retry_cnt;
`ifdef SFP_LINK_STATS_EN
    logic               stats_clr;
    logic [STATS_W-1:0] link_up_count;
    logic [STATS_W-1:0] link_loss_count;
    logic [STATS_W-1:0] timeout_count;

    modport master (
        input  enable, sfp_npres, sfp_los, qpll_lock, rx_block_lock, stats_clr,
        output phy_rst, sfp_tx_disable, sfp_rs, link_up, led, state, retry_cnt,
               link_up_count, link_loss_count, timeout_count
    );
    modport slave (
        output enable, sfp_npres, sfp_los, qpll_lock, rx_block_lock, stats_clr,
        input  phy_rst, sfp_tx_disable, sfp_rs, link_up, led, state, retry_cnt,
               link_up_count, link_loss_count, timeout_count
    );
`else
    modport master (
        input  enable, sfp_npres, sfp_los, qpll_lock, rx_block_lock,
        output phy_rst, sfp_tx_disable, sfp_rs, link_up, led, state, retry_cnt
    );
    modport slave (
        output enable, sfp_npres, sfp_los, qpll_lock, rx_block_lock,
        input  phy_rst, sfp_tx_disable, sfp_rs, link_up, led, state, retry_cnt
    );
`endif
endinterface

// File: rtl/sfp_input_debounce.sv
// 2-flop synchronizer followed by a debouncer: the output flips only after
// the synchronized input has disagreed with it for DEBOUNCE_CYCLES edges.
module sfp_input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 125000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic deb_o
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize, then count consecutive disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
            deb_q  <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/sfp_link_ctrl.sv
// Per-cage SFP+ link bring-up controller: debounced presence/LOS/lock,
// QPLL gating, PHY reset sequencing, lock timeout with backoff and retry.
// Define SFP_LINK_STATS_EN to add the link statistics counters.
module sfp_link_ctrl
    import sfp_link_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 125000,
    parameter int unsigned RESET_CYCLES        = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 12500000,
    parameter int unsigned BACKOFF_CYCLES      = 1250000,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    sfp_link_ctrl_if.master bus
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned T_MAX1  = (LOCK_TIMEOUT_CYCLES > BACKOFF_CYCLES) ? LOCK_TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int unsigned T_MAX   = (T_MAX1 > RESET_CYCLES) ? T_MAX1 : RESET_CYCLES;
    localparam int unsigned TMR_W   = $clog2(T_MAX + 1);
    localparam int unsigned BLINK_W = $clog2(LED_BLINK_HALF);

    link_state_e        state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_sat;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               phy_rst_q, phy_rst_d, tx_dis_q, tx_dis_d, link_up_q, link_up_d;
    logic [1:0]         led_q, led_d;
    logic [1:0]         qpll_sync_q;
    logic               enable_q;
    logic               npres_deb, los_deb, lock_deb, qpll_ok, timer_done;

    sfp_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_npres (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(bus.sfp_npres), .deb_o(npres_deb));
    sfp_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_los (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(bus.sfp_los), .deb_o(los_deb));
    sfp_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_lock (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(bus.rx_block_lock), .deb_o(lock_deb));

    assign qpll_ok    = qpll_sync_q[1];
    assign timer_done = (timer_q <= TMR_W'(1));
    assign retry_sat  = (retry_q == RETRY_W'(MAX_RETRIES)) ? retry_q : retry_q + RETRY_W'(1);

    // Next-state, retry counter and shared timer (reloaded on state entry).
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
        if (npres_deb) begin
            state_d = ST_ABSENT;
            retry_d = '0;
        end else if ((!bus.enable || !qpll_ok) && (state_q != ST_ABSENT) && (state_q != ST_FAULT)) begin
            state_d = ST_WAIT_PLL;
        end else begin
            case (state_q)
                ST_ABSENT:    state_d = ST_WAIT_PLL;
                ST_WAIT_PLL:  if (bus.enable && qpll_ok) state_d = ST_PHY_RST;
                ST_PHY_RST:   if (timer_done) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    // Lock arriving on the expiry cycle still wins.
                    if (lock_deb && !los_deb) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else if (timer_done) begin
                        retry_d = retry_sat;
                        state_d = (retry_sat == RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_BACKOFF;
                    end
                end
                ST_UP:        if (!lock_deb || los_deb) state_d = ST_BACKOFF;
                ST_BACKOFF:   if (timer_done) state_d = ST_PHY_RST;
                ST_FAULT: begin
                    if (enable_q && !bus.enable) begin
                        state_d = ST_WAIT_PLL;
                        retry_d = '0;
                    end
                end
                default:      state_d = ST_ABSENT;
            endcase
        end
        if (state_d != state_q) begin
            case (state_d)
                ST_PHY_RST:   timer_d = TMR_W'(RESET_CYCLES);
                ST_WAIT_LOCK: timer_d = TMR_W'(LOCK_TIMEOUT_CYCLES);
                ST_BACKOFF:   timer_d = TMR_W'(BACKOFF_CYCLES);
                default:      ;
            endcase
        end
    end

    // Output decode from next state so outputs line up with state.
    always_comb begin
        phy_rst_d = 1'b1;
        tx_dis_d  = 1'b1;
        case (state_d)
            ST_PHY_RST, ST_BACKOFF: tx_dis_d = 1'b0;
            ST_WAIT_LOCK, ST_UP: begin
                phy_rst_d = 1'b0;
                tx_dis_d  = 1'b0;
            end
            default: ;
        endcase
        link_up_d = (state_d == ST_UP);
    end

    // FAULT LED blink: lit on entry, toggles every half-period while in FAULT.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if ((state_d == ST_FAULT) && (state_q == ST_FAULT)) begin
            if (blink_cnt_q == BLINK_W'(LED_BLINK_HALF - 1)) begin
                blink_on_d = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_on_d  = blink_on_q;
            end
        end
        led_d = {(state_d == ST_FAULT) && blink_on_d, link_up_d};
    end

    // State, timer, registered outputs and QPLL synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ABSENT;
            retry_q     <= '0;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            phy_rst_q   <= 1'b1;
            tx_dis_q    <= 1'b1;
            link_up_q   <= 1'b0;
            led_q       <= 2'b00;
            qpll_sync_q <= 2'b00;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            phy_rst_q   <= phy_rst_d;
            tx_dis_q    <= tx_dis_d;
            link_up_q   <= link_up_d;
            led_q       <= led_d;
            qpll_sync_q <= {qpll_sync_q[0], bus.qpll_lock};
            enable_q    <= bus.enable;
        end
    end

    assign bus.phy_rst        = phy_rst_q;
    assign bus.sfp_tx_disable = tx_dis_q;
    assign bus.sfp_rs         = 1'b1;
    assign bus.link_up        = link_up_q;
    assign bus.led            = led_q;
    assign bus.state          = state_q;
    assign bus.retry_cnt      = retry_q;

`ifdef SFP_LINK_STATS_EN
    logic [STATS_W-1:0] up_cnt_q, loss_cnt_q, tmo_cnt_q;
    logic               up_evt, loss_evt, tmo_evt;

    assign up_evt   = (state_d == ST_UP) && (state_q != ST_UP);
    assign loss_evt = (state_q == ST_UP) && (state_d == ST_BACKOFF);
    assign tmo_evt  = (state_q == ST_WAIT_LOCK) && ((state_d == ST_BACKOFF) || (state_d == ST_FAULT));

    // Saturating event counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.stats_clr) begin
            up_cnt_q   <= '0;
            loss_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (up_evt)   up_cnt_q   <= stats_inc(up_cnt_q);
            if (loss_evt) loss_cnt_q <= stats_inc(loss_cnt_q);
            if (tmo_evt)  tmo_cnt_q  <= stats_inc(tmo_cnt_q);
        end
    end

    assign bus.link_up_count   = up_cnt_q;
    assign bus.link_loss_count = loss_cnt_q;
    assign bus.timeout_count   = tmo_cnt_q;
`endif

endmodule
